// File: rtl/lives_manager.sv
// Player life counter with hit -> invulnerability/blink -> play sequencing and game-over.
// Optional LIVES_AUTORESTART_EN: OVER returns to IDLE after RESTART_FRAMES frame ticks.
module lives_manager #(
    parameter int START_LIVES    = 3,
    parameter int MAX_LIVES      = 3,
    parameter int INVULN_FRAMES  = 120,
    parameter int BLINK_FRAMES   = 8,
    parameter int RESTART_FRAMES = 180
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       new_game,
    input  logic       hit,
    input  logic       extra_life,
    output logic [1:0] lives,
    output logic       invuln,
    output logic       blink_hide,
    output logic       life_lost,
    output logic       game_over,
    output logic [1:0] state_dbg   // 0 IDLE, 1 PLAY, 2 INVULN, 3 OVER
);

    localparam int INV_W = $clog2(INVULN_FRAMES + 1);
    localparam int BLK_W = $clog2(BLINK_FRAMES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        INVULN = 2'd2,
        OVER   = 2'd3
    } state_t;

    state_t             state;
    logic [INV_W-1:0]   inv_cnt;
    logic [BLK_W-1:0]   blink_cnt;

    // Elaboration-time parameter sanity checks; no hardware is produced.
    if (MAX_LIVES < 1 || MAX_LIVES > 3) begin : g_bad_max
        $error("MAX_LIVES must be 1..3");
    end
    if (START_LIVES < 1 || START_LIVES > MAX_LIVES) begin : g_bad_start
        $error("START_LIVES must be 1..MAX_LIVES");
    end
    if (INVULN_FRAMES < 1 || BLINK_FRAMES < 1 || RESTART_FRAMES < 1) begin : g_bad_frames
        $error("frame counts must be >= 1");
    end

`ifdef LIVES_AUTORESTART_EN
    localparam int RST_W = $clog2(RESTART_FRAMES + 1);
    logic [RST_W-1:0] restart_cnt;
`endif

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lives      <= 2'd0;
            invuln     <= 1'b0;
            blink_hide <= 1'b0;
            life_lost  <= 1'b0;
            game_over  <= 1'b0;
            inv_cnt    <= '0;
            blink_cnt  <= '0;
`ifdef LIVES_AUTORESTART_EN
            restart_cnt <= '0;
`endif
        end else begin
            life_lost <= 1'b0;
            if (new_game) begin
                state      <= PLAY;
                lives      <= 2'(START_LIVES);
                invuln     <= 1'b0;
                blink_hide <= 1'b0;
                game_over  <= 1'b0;
                inv_cnt    <= '0;
                blink_cnt  <= '0;
`ifdef LIVES_AUTORESTART_EN
                restart_cnt <= '0;
`endif
            end else begin
                case (state)
                    PLAY: begin
                        // A hit wins over both extra_life and frame_tick this cycle.
                        if (hit) begin
                            life_lost <= 1'b1;
                            if (lives > 2'd1) begin
                                lives      <= lives - 2'd1;
                                state      <= INVULN;
                                invuln     <= 1'b1;
                                blink_hide <= 1'b1;
                                inv_cnt    <= INV_W'(INVULN_FRAMES);
                                blink_cnt  <= '0;
                            end else begin
                                lives     <= 2'd0;
                                state     <= OVER;
                                game_over <= 1'b1;
`ifdef LIVES_AUTORESTART_EN
                                restart_cnt <= RST_W'(RESTART_FRAMES);
`endif
                            end
                        end else if (extra_life && lives < 2'(MAX_LIVES)) begin
                            lives <= lives + 2'd1;
                        end
                    end
                    INVULN: begin
                        if (extra_life && lives < 2'(MAX_LIVES)) begin
                            lives <= lives + 2'd1;
                        end
                        if (frame_tick) begin
                            inv_cnt <= inv_cnt - INV_W'(1);
                            if (inv_cnt == INV_W'(1)) begin
                                state      <= PLAY;
                                invuln     <= 1'b0;
                                blink_hide <= 1'b0;
                                blink_cnt  <= '0;
                            end else if (blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
                                blink_cnt  <= '0;
                                blink_hide <= ~blink_hide;
                            end else begin
                                blink_cnt <= blink_cnt + BLK_W'(1);
                            end
                        end
                    end
                    OVER: begin
`ifdef LIVES_AUTORESTART_EN
                        if (frame_tick) begin
                            if (restart_cnt <= RST_W'(1)) begin
                                restart_cnt <= '0;
                                state       <= IDLE;
                                game_over   <= 1'b0;
                            end else begin
                                restart_cnt <= restart_cnt - RST_W'(1);
                            end
                        end
`endif
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
